nios_system_onchip_mem_arbiter: RTL and testbench

Shares the single-port 32K x 32 on-chip RAM between NUM_MASTERS Avalon-MM requesters (e.g. CPU data master and a DMA/accelerator master).
- Grants one request per cycle by round-robin and drives the RAM's single port.
- Returns read data with fixed latency 1, steered to the master that issued the read.
- Sits between the interconnect masters and the RAM's address/byteenable/chipselect/write/writedata/readdata pins.

---
 rtl/nios_system_mem_arb_pkg.sv | 21 ++
 rtl/nios_system_rr_arbiter.sv | 43 ++++
 rtl/nios_system_onchip_mem_arbiter.sv | 109 ++++++++++
 tb/tb_nios_system_onchip_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_system_mem_arb_pkg.sv
// Shared definitions for the on-chip RAM arbiter slice.
// Holds the default geometry of the 32K x 32 RAM, the largest supported
// requester count, the index width, and a one-hot to index helper.
package nios_system_mem_arb_pkg;

  localparam int ADDR_W      = 15;
  localparam int DATA_W      = 32;
  localparam int BE_W        = 4;
  localparam int MAX_MASTERS = 4;
  localparam int IDX_W       = 2;

  function automatic logic [IDX_W-1:0] onehot2idx(input logic [MAX_MASTERS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/nios_system_rr_arbiter.sv
// Combinational round-robin grant.
// Searches req_i starting at ptr_i and wraps modulo N. The first requester
// found is granted.
//   req_i     : per-requester request
//   ptr_i     : index with the highest priority this cycle
//   gnt_o     : one-hot grant, all-zero when nothing is requesting
//   gnt_idx_o : binary index of the grant, 0 when there is no grant
module nios_system_rr_arbiter
  import nios_system_mem_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic                   found;
  logic [MAX_MASTERS-1:0] gnt_ext;

  // Outer loop is the priority distance from ptr_i. The inner loop picks out
  // the requester that sits at that distance.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && req_i[i] && ((32'(ptr_i) + k) % N) == i) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_ext        = '0;
    gnt_ext[N-1:0] = gnt_o;
    gnt_idx_o      = onehot2idx(gnt_ext);
  end

endmodule

// File: rtl/nios_system_onchip_mem_arbiter.sv
// Shares the single-port on-chip RAM between NUM_MASTERS Avalon-MM masters.
// The block grants one request per cycle in round-robin order and drives
// the RAM port. Read data returns with a latency of 1 and is steered to the
// master that issued the read.
//   m_*             : packed per-master Avalon-MM slave ports (master i at slice i)
//   m_readdata      : shared read data, qualified per master by m_readdatavalid
//   mem_*           : RAM address/byteenable/chipselect/write/writedata/q pins
//   grant_last      : one-hot master accepted in the last granted cycle (debug)
module nios_system_onchip_mem_arbiter
  import nios_system_mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = nios_system_mem_arb_pkg::ADDR_W,
  parameter int DATA_W      = nios_system_mem_arb_pkg::DATA_W,
  parameter int BE_W        = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS*BE_W-1:0]   m_byteenable,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
  output logic [NUM_MASTERS-1:0]        m_waitrequest,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [NUM_MASTERS-1:0]        m_readdatavalid,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [BE_W-1:0]               mem_byteenable,
  output logic                          mem_chipselect,
  output logic                          mem_write,
  output logic [DATA_W-1:0]             mem_writedata,
  input  logic [DATA_W-1:0]             mem_readdata,
  output logic [NUM_MASTERS-1:0]        grant_last
);

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] gnt_raw;
  logic [NUM_MASTERS-1:0] gnt;
  logic [IDX_W-1:0]       gnt_idx;

  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic                   rd_pend_q, rd_pend_d;
  logic [NUM_MASTERS-1:0] rd_owner_q;
  logic [NUM_MASTERS-1:0] grant_last_q, grant_last_d;

  // When a master asserts both read and write, the request becomes a write.
  assign req = m_read | m_write;

  nios_system_rr_arbiter #(
    .N (NUM_MASTERS)
  ) u_rr_arbiter (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt_raw),
    .gnt_idx_o (gnt_idx)
  );

  // Gate the grant with reset_n. While reset is held, every master sees
  // waitrequest high and the RAM stays deselected.
  assign gnt           = reset_n ? gnt_raw : '0;
  assign m_waitrequest = ~gnt;

  always_comb begin
    mem_address    = m_address[ADDR_W-1:0];
    mem_byteenable = m_byteenable[BE_W-1:0];
    mem_writedata  = m_writedata[DATA_W-1:0];
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (gnt[i]) begin
        mem_address    = m_address[i*ADDR_W +: ADDR_W];
        mem_byteenable = m_byteenable[i*BE_W +: BE_W];
        mem_writedata  = m_writedata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign mem_chipselect = |gnt;
  assign mem_write      = |(gnt & m_write);

  always_comb begin
    ptr_d = ptr_q;
    if (|gnt) begin
      ptr_d = (gnt_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign rd_pend_d    = |(gnt & m_read & ~m_write);
  assign grant_last_d = (|gnt) ? gnt : grant_last_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q        <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= '0;
      grant_last_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= gnt;
      grant_last_q <= grant_last_d;
    end
  end

  // The RAM q output is already one cycle behind its address, so read data
  // passes straight through without a register.
  assign m_readdatavalid = rd_pend_q ? rd_owner_q : '0;
  assign m_readdata      = mem_readdata;
  assign grant_last      = grant_last_q;

endmodule

// File: tb/tb_nios_system_onchip_mem_arbiter.sv
module tb_nios_system_onchip_mem_arbiter;

  localparam int NM = 2;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  logic [NM*AW-1:0] m_address    = '0;
  logic [NM*BW-1:0] m_byteenable = '0;
  logic [NM-1:0]    m_read       = '0;
  logic [NM-1:0]    m_write      = '0;
  logic [NM*DW-1:0] m_writedata  = '0;
  logic [NM-1:0]    m_waitrequest;
  logic [DW-1:0]    m_readdata;
  logic [NM-1:0]    m_readdatavalid;
  logic [AW-1:0]    mem_address;
  logic [BW-1:0]    mem_byteenable;
  logic             mem_chipselect;
  logic             mem_write;
  logic [DW-1:0]    mem_writedata;
  logic [DW-1:0]    mem_readdata;
  logic [NM-1:0]    grant_last;

  int checks = 0;
  int failures = 0;

  nios_system_onchip_mem_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .BE_W        (BW)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .m_address       (m_address),
    .m_byteenable    (m_byteenable),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .mem_address     (mem_address),
    .mem_byteenable  (mem_byteenable),
    .mem_chipselect  (mem_chipselect),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata),
    .grant_last      (grant_last)
  );

  always #5 clk = ~clk;

  // Single-port RAM: writes are byte-enabled, and q is the registered word
  // at the presented address.
  bit   [31:0] ram [0:32767];
  logic [31:0] ram_q = '0;
  always @(posedge clk) begin
    if (mem_chipselect && mem_write) begin
      for (int b = 0; b < BW; b++)
        if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
    end
    ram_q <= ram[mem_address];
  end
  assign mem_readdata = ram_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          ptr_m = 0;
  logic [NM-1:0] gl_m = '0;
  bit          pend_m = 1'b0;
  int          pend_owner = 0;
  logic [31:0] pend_data = '0;
  logic [31:0] mm [int];

  function automatic int exp_grant();
    for (int k = 0; k < NM; k++) begin
      int j;
      j = (ptr_m + k) % NM;
      if (m_read[j] || m_write[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [31:0] mm_get(input int a);
    if (mm.exists(a)) return mm[a];
    return 32'h0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int g;
    int a;
    logic [31:0] w;
    if (!reset_n) begin
      ptr_m  = 0;
      gl_m   = '0;
      pend_m = 1'b0;
    end else begin
      g = exp_grant();
      if (g < 0) begin
        pend_m = 1'b0;
      end else begin
        a = int'(m_address[g*AW +: AW]);
        if (m_write[g]) begin
          w = mm_get(a);
          for (int b = 0; b < BW; b++)
            if (m_byteenable[g*BW + b]) w[b*8 +: 8] = m_writedata[g*DW + b*8 +: 8];
          mm[a]  = w;
          pend_m = 1'b0;
        end else begin
          pend_m     = 1'b1;
          pend_owner = g;
          pend_data  = mm_get(a);
        end
        ptr_m   = (g + 1) % NM;
        gl_m    = '0;
        gl_m[g] = 1'b1;
      end
    end
  end

  // Compare process: every falling edge, the outputs must match the model.
  always @(negedge clk) begin
    int g;
    int s;
    logic [NM-1:0] oh;
    logic [NM-1:0] exp_wr;
    logic [NM-1:0] exp_rdv;
    g  = reset_n ? exp_grant() : -1;
    oh = '0;
    if (g >= 0) oh[g] = 1'b1;
    s = (g >= 0) ? g : 0;
    exp_wr  = ~oh;
    exp_rdv = '0;
    if (pend_m) exp_rdv[pend_owner] = 1'b1;
    chk("waitrequest", m_waitrequest, exp_wr);
    chk("chipselect", mem_chipselect, (g >= 0));
    chk("mem_write", mem_write, (g >= 0) ? m_write[s] : 1'b0);
    chk("mem_address", mem_address, m_address[s*AW +: AW]);
    chk("mem_byteenable", mem_byteenable, m_byteenable[s*BW +: BW]);
    chk("mem_writedata", mem_writedata, m_writedata[s*DW +: DW]);
    chk("readdatavalid", m_readdatavalid, exp_rdv);
    if (pend_m) chk("readdata", m_readdata, pend_data);
    chk("grant_last", grant_last, gl_m);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_read  = '0;
    m_write = '0;
  endtask

  task automatic drive(input int i, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [BW-1:0] be, input logic [DW-1:0] d);
    m_read[i]                = rd;
    m_write[i]               = wr;
    m_address[i*AW +: AW]    = a;
    m_byteenable[i*BW +: BW] = be;
    m_writedata[i*DW +: DW]  = d;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    m_read = 2'b11;
    tick();
    tick();
    @(negedge clk);
    chk("lit_reset_waitrequest", m_waitrequest, 2'b11);
    chk("lit_reset_chipselect", mem_chipselect, 1'b0);
    chk("lit_reset_rdv", m_readdatavalid, 2'b00);
    chk("lit_reset_grant_last", grant_last, 2'b00);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("lit_first_grant_m0", m_waitrequest, 2'b10);
    tick();
    idle();

    // single write then read
    drive(0, 1'b0, 1'b1, 15'h0010, 4'hF, 32'hDEADBEEF);
    tick();
    drive(0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'h0);
    tick();
    idle();
    @(negedge clk);
    chk("lit_rd_valid", m_readdatavalid, 2'b01);
    chk("lit_rd_data", m_readdata, 32'hDEADBEEF);
    tick();

    // byte enables
    drive(0, 1'b0, 1'b1, 15'h0020, 4'hF, 32'h11223344);
    tick();
    drive(0, 1'b0, 1'b1, 15'h0020, 4'b0101, 32'hAABBCCDD);
    tick();
    drive(0, 1'b1, 1'b0, 15'h0020, 4'hF, 32'h0);
    tick();
    idle();
    @(negedge clk);
    chk("lit_be_data", m_readdata, 32'h11BB33DD);
    tick();

    // contention
    drive(0, 1'b0, 1'b1, 15'h0001, 4'hF, 32'h00001111);
    tick();
    idle();
    drive(1, 1'b0, 1'b1, 15'h0002, 4'hF, 32'h00002222);
    tick();
    drive(0, 1'b1, 1'b0, 15'h0001, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b0, 15'h0002, 4'hF, 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("lit_cont_addr", mem_address, (k % 2 == 0) ? 15'h0001 : 15'h0002);
      if (k > 0) begin
        chk("lit_cont_rdv", m_readdatavalid, (k % 2 == 1) ? 2'b01 : 2'b10);
        chk("lit_cont_data", m_readdata, (k % 2 == 1) ? 32'h00001111 : 32'h00002222);
      end
      tick();
    end
    idle();
    @(negedge clk);
    chk("lit_cont_last_rdv", m_readdatavalid, 2'b10);
    chk("lit_cont_last_data", m_readdata, 32'h00002222);
    tick();

    // read+write on the same master: the write wins
    drive(1, 1'b1, 1'b1, 15'h0030, 4'hF, 32'h00000005);
    @(negedge clk);
    chk("lit_rw_mem_write", mem_write, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk("lit_rw_no_rdv", m_readdatavalid, 2'b00);
    tick();
    drive(1, 1'b1, 1'b0, 15'h0030, 4'hF, 32'h0);
    tick();
    idle();
    @(negedge clk);
    chk("lit_rw_rdv", m_readdatavalid, 2'b10);
    chk("lit_rw_data", m_readdata, 32'h00000005);
    tick();

    // reset while a read is in flight
    drive(0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'h0);
    tick();
    #1 reset_n = 1'b0;
    m_read = 2'b11;
    @(negedge clk);
    chk("lit_midrst_rdv", m_readdatavalid, 2'b00);
    chk("lit_midrst_waitrequest", m_waitrequest, 2'b11);
    chk("lit_midrst_chipselect", mem_chipselect, 1'b0);
    #2 reset_n = 1'b1;
    #1;
    chk("lit_midrst_ptr0", m_waitrequest, 2'b10);
    tick();
    idle();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
